// File: rtl/frog_input_ctrl.sv
// frog_input_ctrl
//   Turns the four raw DE1 KEY buttons into clean single-cycle move pulses.
//   Each button passes through a 2-flop synchroniser and then a debounce FSM.
//   The FSM produces exactly one pulse for each physical press, and holding the
//   button never produces another. While freeze is high the pulses are masked,
//   but the FSMs keep running. move_count counts the cycles that carry at least
//   one pulse; it saturates instead of wrapping.
// Ports
//   clk        : system clock
//   reset      : synchronous, active-high
//   key_n[3:0] : raw buttons, active-low, asynchronous; [3]=L [2]=U [1]=D [0]=R
//   freeze     : 1 = suppress all move pulses
//   L,R,U,D    : registered single-cycle move pulses
//   move_count : accepted pulse cycles since reset, saturating
module frog_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       key_n,
   input  logic             freeze,
   output logic             L,
   output logic             R,
   output logic             U,
   output logic             D,
   output logic [CNT_W-1:0] move_count
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {StIdle, StPress, StHeld, StRelease} state_e;

   logic [3:0]       sync1_q;
   logic [3:0]       s_q;
   state_e           state_q [4];
   state_e           state_d [4];
   logic [CW-1:0]    cnt_q   [4];
   logic [CW-1:0]    cnt_d   [4];
   logic [3:0]       accept;
   logic [3:0]       pulse_q;
   logic [CNT_W-1:0] count_q;

   // Synchroniser: s=1 means the button is pressed.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         s_q     <= '0;
      end else begin
         sync1_q <= ~key_n;
         s_q     <= sync1_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
         end else begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // FSM next state
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            StIdle: begin
               if (s_q[i]) begin
                  state_d[i] = StPress;
                  cnt_d[i]   = CW'(1);
               end
            end
            StPress: begin
               if (!s_q[i])                 state_d[i] = StIdle;
               else if (cnt_q[i] == CntMax) state_d[i] = StHeld;
               else                         cnt_d[i]   = cnt_q[i] + 1'b1;
            end
            StHeld: begin
               if (!s_q[i]) begin
                  state_d[i] = StRelease;
                  cnt_d[i]   = CW'(1);
               end
            end
            StRelease: begin
               if (s_q[i])                  state_d[i] = StHeld;
               else if (cnt_q[i] == CntMax) state_d[i] = StIdle;
               else                         cnt_d[i]   = cnt_q[i] + 1'b1;
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   // FSM output: a press is accepted on the PRESS -> HELD transition.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         accept[i] = (state_q[i] == StPress) && s_q[i] && (cnt_q[i] == CntMax);
      end
   end

   // A press accepted during freeze is consumed, not deferred.
   always_ff @(posedge clk) begin
      if (reset) pulse_q <= '0;
      else       pulse_q <= accept & {4{~freeze}};
   end

   // Counts cycles with any pulse, not individual buttons.
   always_ff @(posedge clk) begin
      if (reset)                              count_q <= '0;
      else if (|pulse_q && (count_q != '1))   count_q <= count_q + 1'b1;
   end

   assign L          = pulse_q[3];
   assign U          = pulse_q[2];
   assign D          = pulse_q[1];
   assign R          = pulse_q[0];
   assign move_count = count_q;

endmodule
